// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_seq_pkg
// Description : Shared types and constants for the program-counter sequencer.
//               Contains the state enumeration, opcode encodings, field widths
//               and the control vector that is passed from the decoder to the
//               sequencer output register.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_seq_pkg;

    localparam int INSTR_W = 8;   // instruction / count width
    localparam int FIELD_W = 6;   // jump destination / branch offset width
    localparam int OP_W    = 2;   // opcode width (also PC line-select width)

    localparam logic [OP_W-1:0] OP_ADV  = 2'b00;
    localparam logic [OP_W-1:0] OP_JMP  = 2'b01;
    localparam logic [OP_W-1:0] OP_BRC  = 2'b10;
    localparam logic [OP_W-1:0] OP_HALT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_UPDATE = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    // Control vector produced by the decoder and registered by the sequencer.
    typedef struct packed {
        logic               update_lsbs;
        logic               update_msbs;
        logic               jump;
        logic               branch;
        logic [FIELD_W-1:0] jump_destination;
        logic [FIELD_W-1:0] branch_offset;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

endpackage : pc_seq_pkg
`default_nettype wire

// File: rtl/pc_seq_decoder.sv
`default_nettype none
// ============================================================================
// Module      : pc_seq_decoder
// Description : Purely combinational instruction decoder. Maps the fetched
//               instruction, the branch condition and the current PC line
//               select bits to the control vector to be issued in UPDATE.
// Ports       : instr      - fetched instruction
//               cond_flag  - branch condition
//               pc_lsbs    - mem_addr[1:0], line select within a block
//               ctrl       - control vector for the UPDATE cycle
//               halt       - instruction is the halt opcode
// Revision    : 1.0 - initial release
// ============================================================================
module pc_seq_decoder
    import pc_seq_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    input  logic               cond_flag,
    input  logic [OP_W-1:0]    pc_lsbs,
    output ctrl_t              ctrl,
    output logic               halt
);

    logic [OP_W-1:0]    w_opcode;
    logic [FIELD_W-1:0] w_field;
    ctrl_t              w_advance;

    assign w_opcode = instr[INSTR_W-1 -: OP_W];
    assign w_field  = instr[FIELD_W-1:0];

    // Sequential advance: the last line of a block rolls into the next block
    // instead of carrying from the LSBs, so exactly one strobe fires.
    always_comb begin
        w_advance = CTRL_NONE;
        if (pc_lsbs == 2'b11) begin
            w_advance.update_msbs = 1'b1;
        end else begin
            w_advance.update_lsbs = 1'b1;
        end
    end

    always_comb begin
        ctrl = CTRL_NONE;
        halt = 1'b0;
        unique case (w_opcode)
            OP_ADV: begin
                ctrl = w_advance;
            end
            OP_JMP: begin
                ctrl.jump             = 1'b1;
                ctrl.jump_destination = w_field;
            end
            OP_BRC: begin
                if (cond_flag) begin
                    ctrl.branch        = 1'b1;
                    ctrl.branch_offset = w_field;
                end else begin
                    ctrl = w_advance;
                end
            end
            OP_HALT: begin
                halt = 1'b1;
            end
            default: begin
                ctrl = CTRL_NONE;
            end
        endcase
    end

endmodule : pc_seq_decoder
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Three-cycle instruction sequencer (FETCH, DECODE, UPDATE) that
//               issues single-cycle PC update strobes. HALT parks the block in
//               HALTED until stop or reset.
// Ports       : clk, rst_n       - clock, asynchronous active-low reset
//               start            - begin fetching (accepted in IDLE only)
//               stop             - synchronous abort to IDLE from any state
//               instr            - memory read data
//               mem_addr         - current PC; only [1:0] are used
//               cond_flag        - branch condition, sampled in DECODE
//               update_lsbs/msbs - PC increment strobes
//               jump, jump_destination, branch, branch_offset
//                                - PC load / relative branch strobes + data
//               busy, halted     - status
//               instr_count      - saturating count of decoded instructions
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [INSTR_W-1:0] instr,
    input  logic [INSTR_W-1:0] mem_addr,
    input  logic               cond_flag,
    output logic               update_lsbs,
    output logic               update_msbs,
    output logic               jump,
    output logic [FIELD_W-1:0] jump_destination,
    output logic               branch,
    output logic [FIELD_W-1:0] branch_offset,
    output logic               busy,
    output logic               halted,
    output logic [INSTR_W-1:0] instr_count
);

    localparam logic [INSTR_W-1:0] C_COUNT_MAX = '1;

    state_t             r_state;
    state_t             w_state_next;
    ctrl_t              r_ctrl;
    ctrl_t              w_dec_ctrl;
    logic               w_dec_halt;
    logic [INSTR_W-1:0] r_count;
    logic               w_unused_addr;

    // Upper PC bits belong to the PC block itself; only the line select
    // matters for choosing between the LSB and MSB strobes.
    assign w_unused_addr = ^mem_addr[INSTR_W-1:OP_W];

    pc_seq_decoder u_decoder (
        .instr     (instr),
        .cond_flag (cond_flag),
        .pc_lsbs   (mem_addr[OP_W-1:0]),
        .ctrl      (w_dec_ctrl),
        .halt      (w_dec_halt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:   if (start) w_state_next = ST_FETCH;
            ST_FETCH:  w_state_next = ST_DECODE;
            ST_DECODE: w_state_next = w_dec_halt ? ST_HALTED : ST_UPDATE;
            ST_UPDATE: w_state_next = ST_FETCH;
            ST_HALTED: w_state_next = ST_HALTED;
            default:   w_state_next = ST_IDLE;
        endcase
        if (stop) begin
            w_state_next = ST_IDLE;
        end
    end

    // The control vector is captured only on the edge that enters UPDATE, so
    // every strobe is registered and lives for exactly that one cycle. A stop
    // during UPDATE does not touch the already-registered pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl <= CTRL_NONE;
        end else if (w_state_next == ST_UPDATE) begin
            r_ctrl <= w_dec_ctrl;
        end else begin
            r_ctrl <= CTRL_NONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (r_state == ST_IDLE && start && !stop) begin
            r_count <= '0;
        end else if (r_state == ST_DECODE && r_count != C_COUNT_MAX) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign update_lsbs      = r_ctrl.update_lsbs;
    assign update_msbs      = r_ctrl.update_msbs;
    assign jump             = r_ctrl.jump;
    assign jump_destination = r_ctrl.jump_destination;
    assign branch           = r_ctrl.branch;
    assign branch_offset    = r_ctrl.branch_offset;
    assign busy             = (r_state == ST_FETCH) || (r_state == ST_DECODE) ||
                              (r_state == ST_UPDATE);
    assign halted           = (r_state == ST_HALTED);
    assign instr_count      = r_count;

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking testbench for pc_sequencer. Expected output
//               vectors are pushed to a scoreboard queue when an instruction
//               is presented and popped when the UPDATE (or HALTED) cycle
//               is reached.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [7:0] instr;
    logic [7:0] mem_addr;
    logic       cond_flag;
    logic       update_lsbs;
    logic       update_msbs;
    logic       jump;
    logic [5:0] jump_destination;
    logic       branch;
    logic [5:0] branch_offset;
    logic       busy;
    logic       halted;
    logic [7:0] instr_count;

    // {lsbs, msbs, jump, branch, jdest[5:0], boff[5:0], busy, halted, count[7:0]}
    logic [25:0] obs;
    logic [25:0] exp_v;
    logic [25:0] sb_q[$];
    logic [7:0]  exp_count;
    int          n_total;
    int          n_pass;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .stop             (stop),
        .instr            (instr),
        .mem_addr         (mem_addr),
        .cond_flag        (cond_flag),
        .update_lsbs      (update_lsbs),
        .update_msbs      (update_msbs),
        .jump             (jump),
        .jump_destination (jump_destination),
        .branch           (branch),
        .branch_offset    (branch_offset),
        .busy             (busy),
        .halted           (halted),
        .instr_count      (instr_count)
    );

    assign obs = {update_lsbs, update_msbs, jump, branch, jump_destination,
                  branch_offset, busy, halted, instr_count};

    // Reference model: outputs expected in the cycle after DECODE.
    function automatic logic [25:0] model(input logic [7:0] ins, input logic [7:0] addr,
                                          input logic c, input logic [7:0] cnt);
        logic       l, m, j, b, bz, h;
        logic [5:0] jd, bo;
        l = 0; m = 0; j = 0; b = 0; jd = 0; bo = 0; bz = 1; h = 0;
        case (ins[7:6])
            2'b00: if (addr[1:0] == 2'b11) m = 1; else l = 1;
            2'b01: begin j = 1; jd = ins[5:0]; end
            2'b10: begin
                if (c) begin b = 1; bo = ins[5:0]; end
                else if (addr[1:0] == 2'b11) m = 1;
                else l = 1;
            end
            default: begin bz = 0; h = 1; end
        endcase
        return {l, m, j, b, jd, bo, bz, h, cnt};
    endfunction

    // Accept start in IDLE; returns with the DUT in FETCH.
    task automatic start_prog();
        start = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        exp_count = 8'h00;
    endtask

    // Present an instruction during FETCH, record the expected result, and
    // return one step after the DECODE edge (UPDATE or HALTED).
    task automatic issue(input logic [7:0] ins, input logic [7:0] addr, input logic c);
        instr     = ins;
        mem_addr  = addr;
        cond_flag = c;
        if (exp_count != 8'hFF) exp_count = exp_count + 8'h01;
        sb_q.push_back(model(ins, addr, c, exp_count));
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 0; stop = 0; instr = 0; mem_addr = 0; cond_flag = 0;
        exp_count = 0;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (obs !== 26'h0) $display("FAIL reset_outputs: got %h expected %h", obs, 26'h0);
        else n_pass++;
        rst_n = 1'b1;
        repeat (3) next_cycle();
        n_total++;
        if (obs !== 26'h0) $display("FAIL reset_idle: got %h expected %h", obs, 26'h0);
        else n_pass++;
    endtask

    task automatic test_advance();
        start_prog();
        n_total++;
        if (obs !== 26'h200) $display("FAIL adv_fetch: got %h expected %h", obs, 26'h200);
        else n_pass++;
        issue(8'h00, 8'h01, 1'b0);
        exp_v = sb_q.pop_front();
        n_total++;
        if (obs !== exp_v) $display("FAIL adv_lsbs: got %h expected %h", obs, exp_v);
        else n_pass++;
        next_cycle();
        exp_v = {18'h00200 >> 8, exp_count};
        exp_v = {16'h0, 2'b10, exp_count};
        n_total++;
        if (obs !== exp_v) $display("FAIL adv_one_cycle: got %h expected %h", obs, exp_v);
        else n_pass++;
        issue(8'h00, 8'h03, 1'b0);
        exp_v = sb_q.pop_front();
        n_total++;
        if (obs !== exp_v) $display("FAIL adv_msbs: got %h expected %h", obs, exp_v);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_jump();
        issue(8'h4F, 8'h00, 1'b0);
        exp_v = sb_q.pop_front();
        n_total++;
        if (obs !== exp_v) $display("FAIL jmp_0f: got %h expected %h", obs, exp_v);
        else n_pass++;
        next_cycle();
        exp_v = {16'h0, 2'b10, exp_count};
        n_total++;
        if (obs !== exp_v) $display("FAIL jmp_one_cycle: got %h expected %h", obs, exp_v);
        else n_pass++;
        issue(8'h4A, 8'h02, 1'b1);
        exp_v = sb_q.pop_front();
        n_total++;
        if (obs !== exp_v) $display("FAIL jmp_0a: got %h expected %h", obs, exp_v);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_branch();
        issue(8'hBF, 8'h01, 1'b1);
        exp_v = sb_q.pop_front();
        n_total++;
        if (obs !== exp_v) $display("FAIL brc_taken: got %h expected %h", obs, exp_v);
        else n_pass++;
        next_cycle();
        issue(8'hBF, 8'h28, 1'b0);
        exp_v = sb_q.pop_front();
        n_total++;
        if (obs !== exp_v) $display("FAIL brc_not_taken: got %h expected %h", obs, exp_v);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [7:0] t_ins [8]  = '{8'h00, 8'h7F, 8'h81, 8'h8C, 8'h03, 8'h40, 8'hA5, 8'h3E};
        logic [7:0] t_addr[8]  = '{8'h02, 8'h13, 8'hFF, 8'h07, 8'hFB, 8'h00, 8'h03, 8'h10};
        logic       t_c   [8]  = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1};
        for (int i = 0; i < 8; i++) begin
            issue(t_ins[i], t_addr[i], t_c[i]);
            exp_v = sb_q.pop_front();
            n_total++;
            if (obs !== exp_v) $display("FAIL b2b_%0d: got %h expected %h", i, obs, exp_v);
            else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_halt();
        issue(8'hFF, 8'h01, 1'b1);
        exp_v = sb_q.pop_front();
        n_total++;
        if (obs !== exp_v) $display("FAIL halt_state: got %h expected %h", obs, exp_v);
        else n_pass++;
        start = 1'b1;
        repeat (2) next_cycle();
        start = 1'b0;
        exp_v = {16'h0, 2'b01, exp_count};
        n_total++;
        if (obs !== exp_v) $display("FAIL halt_ignore_start: got %h expected %h", obs, exp_v);
        else n_pass++;
        stop = 1'b1;
        next_cycle();
        stop = 1'b0;
        exp_v = {18'h0, exp_count};
        n_total++;
        if (obs !== exp_v) $display("FAIL halt_stop: got %h expected %h", obs, exp_v);
        else n_pass++;
    endtask

    task automatic test_stop_update();
        start_prog();
        issue(8'h4F, 8'h00, 1'b0);
        stop  = 1'b1;
        exp_v = sb_q.pop_front();
        n_total++;
        if (obs !== exp_v) $display("FAIL stop_upd_pulse: got %h expected %h", obs, exp_v);
        else n_pass++;
        next_cycle();
        stop  = 1'b0;
        exp_v = {18'h0, exp_count};
        n_total++;
        if (obs !== exp_v) $display("FAIL stop_upd_idle: got %h expected %h", obs, exp_v);
        else n_pass++;
    endtask

    task automatic test_saturate();
        start_prog();
        for (int i = 0; i < 300; i++) begin
            issue(8'h00, i[7:0], 1'b0);
            exp_v = sb_q.pop_front();
            n_total++;
            if (obs !== exp_v) $display("FAIL sat_%0d: got %h expected %h", i, obs, exp_v);
            else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        issue(8'h4A, 8'h00, 1'b0);
        exp_v = sb_q.pop_front();
        n_total++;
        if (obs !== exp_v) $display("FAIL rstmid_jump: got %h expected %h", obs, exp_v);
        else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_total++;
        if (obs !== 26'h0) $display("FAIL rstmid_drop: got %h expected %h", obs, 26'h0);
        else n_pass++;
        @(posedge clk); #1;
        rst_n     = 1'b1;
        exp_count = 8'h00;
        repeat (2) next_cycle();
        n_total++;
        if (obs !== 26'h0) $display("FAIL rstmid_idle: got %h expected %h", obs, 26'h0);
        else n_pass++;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        test_reset();
        test_advance();
        test_jump();
        test_branch();
        test_back_to_back();
        test_halt();
        test_stop_update();
        test_saturate();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_pc_sequencer
`default_nettype wire
